soc_sprite_fetch: RTL and testbench
===================================

SOC_SPRITE_FETCH -- requirements
Module: soc_sprite_fetch

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning the number of sprite attribute slots; legal range 1-4.
REQ-002 SHALL have port clk  in  1  system clock; all logic SHALL be on the rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port line_start  in  1  single-cycle pulse: prepare sprite data for line vcount.
REQ-005 SHALL have port vcount  in  10  line number to prepare, sampled when line_start is high.
REQ-006 SHALL have port attr_write  in  1  attribute slot write strobe.
REQ-007 SHALL have port attr_address  in  2  slot index; writes to index >= NUM_SLOTS are ignored.
REQ-008 SHALL have port attr_writedata  in  32  [31] enable, [30] hflip, [29:26] sprite id, [25:16] y, [9:0] x.
REQ-009 SHALL have port rom_address  out  8  sprite ROM word address {id[3:0], row[3:0]}.
REQ-010 SHALL have port rom_chipselect  out  1  ROM read request.
REQ-011 SHALL have port rom_readdata  in  32  ROM data, valid the cycle after rom_chipselect is high.
REQ-012 SHALL have port pix_x  in  10  column queried by the display pipeline.
REQ-013 SHALL have port pix_opaque  out  1  a non-transparent sprite pixel covers pix_x.
REQ-014 SHALL have port pix_color  out  2  colour index of the winning pixel.
REQ-015 SHALL have port fetch_busy  out  1  high while the fetch FSM is not IDLE.

Function
REQ-016 Sprite format: 16x16 pixels, 2 bpp, one 32-bit ROM word per row; leftmost pixel in bits [1:0]; index 0 is transparent.
REQ-017 FSM states SHALL be IDLE, SCAN, FETCH, CAPTURE.
REQ-018 On line_start: active set <= shadow set, slot counter <= 0, state <= SCAN, from any state.
REQ-019 In SCAN: row = vcount - y (11-bit unsigned); hit when the slot is enabled and row < 16. Hit -> FETCH. Miss -> shadow hit flag cleared and the FSM advances to the next slot.
REQ-020 In FETCH: rom_chipselect = 1 for exactly one cycle with rom_address = {id, row[3:0]}; the next state is CAPTURE.
REQ-021 In CAPTURE: shadow word, x and hit flag are latched from rom_readdata; the FSM then advances to the next slot.
REQ-022 After the last slot the FSM SHALL return to IDLE; worst-case fetch is 3*NUM_SLOTS cycles.
REQ-023 Pixel lookup SHALL have 1-cycle latency: offset = pix_x - x; a slot covers pix_x when its active hit flag is set and offset < 16. The lowest covering slot with a non-zero pixel wins.
REQ-024 No winner -> pix_opaque = 0 and pix_color = 0.
REQ-025 line_start during SCAN/FETCH/CAPTURE SHALL abort the fetch. Slots not yet fetched are committed with hit = 0, and the fetch restarts.
REQ-026 An attribute write SHALL take effect at the next SCAN of that slot. If a write coincides with a SCAN of the same slot, the SCAN uses the old value.
REQ-027 The row subtraction SHALL treat y > vcount as a miss (no wrap). A sprite with x > 1008 is clipped at column 1023.

Reset
REQ-028 Reset SHALL set: state IDLE; all attributes, shadow and active sets 0 (disabled); rom_chipselect, rom_address, pix_opaque, pix_color and fetch_busy all 0.
REQ-029 Reset mid-fetch SHALL abandon the fetch with no ROM request issued afterwards.

Configuration
REQ-030 With SPRITE_HFLIP_EN defined, attr bit 30 set SHALL mirror the row, so the winning pixel index is 15 - offset. Without the macro, bit 30 SHALL be ignored and stored as 0.

Structure
REQ-031 A shared package soc_sprite_pkg SHALL hold the attribute field positions, SPRITE_W = 16, BPP = 2, the transparent index and the FSM state enum.
REQ-032 One sub-module, soc_sprite_pixel_sel, SHALL implement the combinational priority pixel selection of REQ-023.

Verification
REQ-033 Slot0 = {en, id 3, y 100, x 200}, line_start with vcount 105 -> one ROM read at address 0x35; pix_x 200 returns the pixel from bits [1:0] one cycle later.
REQ-034 Slots 0 and 1 overlap at x 50, slot0 pixel transparent and slot1 colour 2 -> pix_color 2. With slot0 opaque colour 1 -> pix_color 1.
REQ-035 vcount 99 with y 100, and vcount 116 with y 100 -> no ROM read for that slot; pix_opaque = 0.
REQ-036 Second line_start 3 cycles after the first -> fetch restarts; unfetched slots are not displayed on that line; no duplicate rom_chipselect pulse.
REQ-037 With SPRITE_HFLIP_EN, row word 0x00000001 and hflip set -> only offset 15 is opaque. Without the macro -> only offset 0 is opaque.
REQ-038 reset_n asserted while in FETCH -> all outputs 0 asynchronously; no ROM request until the next line_start.

Source files
------------

// File: rtl/soc_sprite_pkg.sv
// Shared definitions for the sprite fetch block: attribute field layout,
// sprite geometry, fetch FSM states and the per-slot record types.
package soc_sprite_pkg;

  // Attribute word layout
  localparam int unsigned ATTR_EN_BIT    = 31;
  localparam int unsigned ATTR_HFLIP_BIT = 30;
  localparam int unsigned ATTR_ID_LSB    = 26;
  localparam int unsigned ATTR_Y_LSB     = 16;
  localparam int unsigned ATTR_X_LSB     = 0;

  // Sprite geometry: 16x16 pixels, 2 bits per pixel, one ROM word per row
  localparam int unsigned SPRITE_W        = 16;
  localparam int unsigned SPRITE_ROW_BITS = $clog2(SPRITE_W);
  localparam int unsigned BPP             = 2;
  localparam logic [1:0]  TRANSPARENT     = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FETCH,
    CAPTURE
  } fetch_state_t;

  // Programmed attributes of one slot
  typedef struct packed {
    logic       en;
    logic       hflip;
    logic [3:0] id;
    logic [9:0] y;
    logic [9:0] x;
  } attr_t;

  // Row data prepared for one slot (shadow and active sets)
  typedef struct packed {
    logic        hit;
    logic        hflip;
    logic [9:0]  x;
    logic [31:0] word;
  } slot_t;

endpackage

// File: rtl/soc_sprite_pixel_sel.sv
// Combinational priority pixel selection: the lowest-numbered slot that
// covers pix_x with a non-transparent pixel supplies the colour.
module soc_sprite_pixel_sel
  import soc_sprite_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic [9:0]                 pix_x,
  input  slot_t [NUM_SLOTS-1:0]      slots,
  output logic                       opaque,
  output logic [1:0]                 color
);

  // Walk slots in priority order; first covering opaque pixel wins
  always_comb begin
    opaque = 1'b0;
    color  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      logic [10:0] diff;
      logic [3:0]  idx;
      logic [1:0]  pix;
      // 11-bit difference: columns left of x go negative and never cover
      diff = {1'b0, pix_x} - {1'b0, slots[i].x};
      // Mirrored index 15 - offset is the bitwise complement of a 4-bit offset
      idx  = slots[i].hflip ? ~diff[3:0] : diff[3:0];
      pix  = slots[i].word[int'(idx) * BPP +: BPP];
      if (!opaque && slots[i].hit && (diff[10:SPRITE_ROW_BITS] == '0) &&
          (pix != TRANSPARENT)) begin
        opaque = 1'b1;
        color  = pix;
      end
    end
  end

endmodule

// File: rtl/soc_sprite_fetch.sv
// Sprite line fetch: scans attribute slots for the line given on line_start,
// reads one ROM row per hit into a shadow set, and swaps shadow into the
// active set on the following line_start for 1-cycle pixel lookup.
// Optional feature macro: SPRITE_HFLIP_EN (attribute bit 30 mirrors the row).
module soc_sprite_fetch
  import soc_sprite_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  vcount,
  input  logic        attr_write,
  input  logic [1:0]  attr_address,
  input  logic [31:0] attr_writedata,
  output logic [7:0]  rom_address,
  output logic        rom_chipselect,
  input  logic [31:0] rom_readdata,
  input  logic [9:0]  pix_x,
  output logic        pix_opaque,
  output logic [1:0]  pix_color,
  output logic        fetch_busy
);

  attr_t [NUM_SLOTS-1:0] attr;
  slot_t [NUM_SLOTS-1:0] shadow;
  slot_t [NUM_SLOTS-1:0] active;

  fetch_state_t state;
  logic [1:0]   slot;
  logic [9:0]   vcount_q;
  logic [9:0]   cur_x;
  logic         cur_hflip;

  attr_t        cur_attr;
  logic [10:0]  scan_row;
  logic         scan_hit;
  logic         last_slot;

  logic         sel_opaque;
  logic [1:0]   sel_color;

  logic         unused_attr_bits;
  assign unused_attr_bits = ^{attr_writedata[15:10], attr_writedata[ATTR_HFLIP_BIT]};

  // Attribute slot writes; out-of-range indices match no slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      attr <= '0;
    end else if (attr_write) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (attr_address == 2'(i)) begin
          attr[i].en <= attr_writedata[ATTR_EN_BIT];
`ifdef SPRITE_HFLIP_EN
          attr[i].hflip <= attr_writedata[ATTR_HFLIP_BIT];
`else
          attr[i].hflip <= 1'b0;
`endif
          attr[i].id <= attr_writedata[ATTR_ID_LSB +: 4];
          attr[i].y  <= attr_writedata[ATTR_Y_LSB +: 10];
          attr[i].x  <= attr_writedata[ATTR_X_LSB +: 10];
        end
      end
    end
  end

  // Select the attributes of the slot under scan and test the line against them
  always_comb begin
    cur_attr = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot == 2'(i)) cur_attr = attr[i];
    end
    // No wrap: y > vcount sets bit 10 and fails the range test
    scan_row  = {1'b0, vcount_q} - {1'b0, cur_attr.y};
    scan_hit  = cur_attr.en && (scan_row[10:SPRITE_ROW_BITS] == '0);
    last_slot = (slot == 2'(NUM_SLOTS - 1));
  end

  // Fetch FSM: SCAN -> (FETCH -> CAPTURE) per slot, restartable by line_start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      slot           <= '0;
      vcount_q       <= '0;
      cur_x          <= '0;
      cur_hflip      <= 1'b0;
      rom_chipselect <= 1'b0;
      rom_address    <= '0;
      fetch_busy     <= 1'b0;
      shadow         <= '0;
      active         <= '0;
    end else begin
      rom_chipselect <= 1'b0;
      if (line_start) begin
        // Slots at or beyond the scan pointer of an interrupted fetch hold
        // stale rows from an earlier line, so they are committed as misses
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          active[i] <= shadow[i];
          if ((state != IDLE) && (2'(i) >= slot)) active[i].hit <= 1'b0;
        end
        vcount_q   <= vcount;
        slot       <= '0;
        state      <= SCAN;
        fetch_busy <= 1'b1;
      end else begin
        case (state)
          SCAN: begin
            if (scan_hit) begin
              rom_chipselect <= 1'b1;
              rom_address    <= {cur_attr.id, scan_row[3:0]};
              cur_x          <= cur_attr.x;
              cur_hflip      <= cur_attr.hflip;
              state          <= FETCH;
            end else begin
              for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (slot == 2'(i)) shadow[i].hit <= 1'b0;
              end
              if (last_slot) begin
                state      <= IDLE;
                fetch_busy <= 1'b0;
              end else begin
                slot <= slot + 2'd1;
              end
            end
          end
          FETCH: begin
            state <= CAPTURE;
          end
          CAPTURE: begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (slot == 2'(i)) begin
                shadow[i].hit   <= 1'b1;
                shadow[i].hflip <= cur_hflip;
                shadow[i].x     <= cur_x;
                shadow[i].word  <= rom_readdata;
              end
            end
            if (last_slot) begin
              state      <= IDLE;
              fetch_busy <= 1'b0;
            end else begin
              slot  <= slot + 2'd1;
              state <= SCAN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  soc_sprite_pixel_sel #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_pixel_sel (
    .pix_x  (pix_x),
    .slots  (active),
    .opaque (sel_opaque),
    .color  (sel_color)
  );

  // Register the pixel lookup result (one cycle latency)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_opaque <= 1'b0;
      pix_color  <= '0;
    end else begin
      pix_opaque <= sel_opaque;
      pix_color  <= sel_color;
    end
  end

endmodule

// File: tb/tb_soc_sprite_fetch.sv
// Directed self-checking bench for soc_sprite_fetch (default NUM_SLOTS = 4).
module tb_soc_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  vcount = '0;
  logic        attr_write = 1'b0;
  logic [1:0]  attr_address = '0;
  logic [31:0] attr_writedata = '0;
  logic [7:0]  rom_address;
  logic        rom_chipselect;
  logic [31:0] rom_readdata = '0;
  logic [9:0]  pix_x = '0;
  logic        pix_opaque;
  logic [1:0]  pix_color;
  logic        fetch_busy;

  logic [31:0] rom_mem [256];
  int          cs_count = 0;
  logic [7:0]  last_addr = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          c0;

  soc_sprite_fetch #(.NUM_SLOTS(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start     (line_start),
    .vcount         (vcount),
    .attr_write     (attr_write),
    .attr_address   (attr_address),
    .attr_writedata (attr_writedata),
    .rom_address    (rom_address),
    .rom_chipselect (rom_chipselect),
    .rom_readdata   (rom_readdata),
    .pix_x          (pix_x),
    .pix_opaque     (pix_opaque),
    .pix_color      (pix_color),
    .fetch_busy     (fetch_busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the address is presented
  always @(posedge clk) rom_readdata <= rom_mem[rom_address];

  // Count ROM read pulses and remember the last address requested
  always @(posedge clk) begin
    if (rom_chipselect) begin
      cs_count  <= cs_count + 1;
      last_addr <= rom_address;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_attr(input logic [1:0] idx, input logic en, input logic hf,
                            input logic [3:0] id, input logic [9:0] y, input logic [9:0] x);
    attr_write     = 1'b1;
    attr_address   = idx;
    attr_writedata = {en, hf, id, y, 6'b0, x};
    @(posedge clk); #1;
    attr_write     = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] v);
    line_start = 1'b1;
    vcount     = v;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fetch_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (fetch_busy) check("wait_idle_timeout", 32'(fetch_busy), 32'd0);
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic op, input logic [1:0] col);
    pix_x = x;
    @(posedge clk); #1;
    check({tag, "_opaque"}, 32'(pix_opaque), 32'(op));
    check({tag, "_color"}, 32'(pix_color), 32'(col));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", 32'(rom_chipselect), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_opaque", 32'(pix_opaque), 32'd0);
    check("rst_color", 32'(pix_color), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single sprite: id 3, y 100, x 200, line 105 -> row 5 -> address 0x35
    rom_mem[8'h35] = 32'h8000_0003;
    write_attr(2'd0, 1'b1, 1'b0, 4'd3, 10'd100, 10'd200);
    c0 = cs_count;
    start_line(10'd105);
    check("t1_busy", 32'(fetch_busy), 32'd1);
    @(posedge clk); #1;
    check("t1_cs_fetch", 32'(rom_chipselect), 32'd1);
    check("t1_addr", 32'(rom_address), 32'h35);
    @(posedge clk); #1;
    check("t1_cs_single", 32'(rom_chipselect), 32'd0);
    wait_idle();
    check("t1_reads", 32'(cs_count - c0), 32'd1);
    start_line(10'd105);
    pix_x = 10'd200;
    #1;
    check("t1_latency", 32'(pix_opaque), 32'd0);
    @(posedge clk); #1;
    check("t1_px200_opaque", 32'(pix_opaque), 32'd1);
    check("t1_px200_color", 32'(pix_color), 32'd3);
    probe("t1_px201", 10'd201, 1'b0, 2'd0);
    probe("t1_px215", 10'd215, 1'b1, 2'd2);
    probe("t1_px216", 10'd216, 1'b0, 2'd0);
    probe("t1_px199", 10'd199, 1'b0, 2'd0);
    wait_idle();

    // Overlap at x 50: slot0 transparent then opaque, slot1 colour 2
    rom_mem[8'h10] = 32'h0000_0000;
    rom_mem[8'h20] = 32'h0000_0002;
    write_attr(2'd0, 1'b1, 1'b0, 4'd1, 10'd100, 10'd50);
    write_attr(2'd1, 1'b1, 1'b0, 4'd2, 10'd100, 10'd50);
    c0 = cs_count;
    start_line(10'd100);
    wait_idle();
    check("t2_reads", 32'(cs_count - c0), 32'd2);
    start_line(10'd100);
    probe("t2_behind", 10'd50, 1'b1, 2'd2);
    probe("t2_px51", 10'd51, 1'b0, 2'd0);
    wait_idle();
    rom_mem[8'h10] = 32'h0000_0001;
    start_line(10'd100);
    wait_idle();
    start_line(10'd100);
    probe("t2_front", 10'd50, 1'b1, 2'd1);
    wait_idle();

    // Vertical boundaries for y 100: 99 and 116 miss, 115 hits row 15
    write_attr(2'd1, 1'b0, 1'b0, 4'd2, 10'd100, 10'd50);
    write_attr(2'd0, 1'b1, 1'b0, 4'd3, 10'd100, 10'd200);
    c0 = cs_count;
    start_line(10'd99);
    wait_idle();
    check("t3_v99_reads", 32'(cs_count - c0), 32'd0);
    start_line(10'd99);
    probe("t3_v99_px50", 10'd50, 1'b0, 2'd0);
    probe("t3_v99_px200", 10'd200, 1'b0, 2'd0);
    wait_idle();
    c0 = cs_count;
    start_line(10'd116);
    wait_idle();
    check("t3_v116_reads", 32'(cs_count - c0), 32'd0);
    c0 = cs_count;
    start_line(10'd115);
    wait_idle();
    check("t3_v115_reads", 32'(cs_count - c0), 32'd1);
    check("t3_v115_addr", 32'(last_addr), 32'h3F);

    // Write coinciding with the scan of the same slot uses the old value
    c0 = cs_count;
    start_line(10'd115);
    write_attr(2'd0, 1'b0, 1'b0, 4'd3, 10'd100, 10'd200);
    wait_idle();
    check("t4_old_value_reads", 32'(cs_count - c0), 32'd1);
    c0 = cs_count;
    start_line(10'd115);
    wait_idle();
    check("t4_new_value_reads", 32'(cs_count - c0), 32'd0);

    // Abort: restart while scanning slot 1
    rom_mem[8'h40] = 32'h1;
    rom_mem[8'h50] = 32'h1;
    rom_mem[8'h60] = 32'h1;
    rom_mem[8'h70] = 32'h1;
    write_attr(2'd0, 1'b1, 1'b0, 4'd4, 10'd0, 10'd300);
    write_attr(2'd1, 1'b1, 1'b0, 4'd5, 10'd0, 10'd320);
    write_attr(2'd2, 1'b1, 1'b0, 4'd6, 10'd0, 10'd340);
    write_attr(2'd3, 1'b1, 1'b0, 4'd7, 10'd0, 10'd360);
    c0 = cs_count;
    start_line(10'd0);
    wait_idle();
    check("t5_full_reads", 32'(cs_count - c0), 32'd4);
    c0 = cs_count;
    start_line(10'd0);
    repeat (3) @(posedge clk);
    #1;
    start_line(10'd0);
    check("t5_reads_before_abort", 32'(cs_count - c0), 32'd1);
    probe("t5_fetched_slot0", 10'd300, 1'b1, 2'd1);
    probe("t5_unfetched_slot1", 10'd320, 1'b0, 2'd0);
    probe("t5_unfetched_slot3", 10'd360, 1'b0, 2'd0);
    wait_idle();
    check("t5_total_reads", 32'(cs_count - c0), 32'd5);
    start_line(10'd0);
    probe("t5_refetched_slot1", 10'd320, 1'b1, 2'd1);
    probe("t5_refetched_slot3", 10'd360, 1'b1, 2'd1);
    wait_idle();

    // Horizontal flip of row word 0x00000001
    write_attr(2'd1, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0);
    write_attr(2'd2, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0);
    write_attr(2'd3, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0);
    write_attr(2'd0, 1'b1, 1'b1, 4'd8, 10'd0, 10'd400);
    rom_mem[8'h80] = 32'h0000_0001;
    start_line(10'd0);
    wait_idle();
    start_line(10'd0);
    wait_idle();
`ifdef SPRITE_HFLIP_EN
    probe("t6_off0", 10'd400, 1'b0, 2'd0);
    probe("t6_off15", 10'd415, 1'b1, 2'd1);
    pix_x = 10'd415;
`else
    probe("t6_off0", 10'd400, 1'b1, 2'd1);
    probe("t6_off15", 10'd415, 1'b0, 2'd0);
    pix_x = 10'd400;
`endif
    probe("t6_off16", 10'd416, 1'b0, 2'd0);

    // Reset asserted during FETCH
`ifdef SPRITE_HFLIP_EN
    pix_x = 10'd415;
`else
    pix_x = 10'd400;
`endif
    @(posedge clk); #1;
    check("t7_pre_opaque", 32'(pix_opaque), 32'd1);
    start_line(10'd0);
    @(posedge clk); #1;
    check("t7_pre_cs", 32'(rom_chipselect), 32'd1);
    #2;
    reset_n = 1'b0;
    c0 = cs_count;
    #1;
    check("t7_cs", 32'(rom_chipselect), 32'd0);
    check("t7_addr", 32'(rom_address), 32'd0);
    check("t7_busy", 32'(fetch_busy), 32'd0);
    check("t7_opaque", 32'(pix_opaque), 32'd0);
    check("t7_color", 32'(pix_color), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t7_no_reads", 32'(cs_count - c0), 32'd0);
    check("t7_idle", 32'(fetch_busy), 32'd0);
    c0 = cs_count;
    start_line(10'd0);
    wait_idle();
    check("t7_attrs_cleared", 32'(cs_count - c0), 32'd0);
    probe("t7_px400", 10'd400, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
